burst_main_memory: RTL and testbench

BURST_MAIN_MEMORY -- requirements
Module: burst_main_memory

---
 rtl/burst_main_memory_if.sv | 27 ++
 rtl/burst_main_memory.sv | 105 ++++++++++
 tb/tb_burst_main_memory.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_main_memory_if.sv
// Bus bundle for the burst main memory: request, write-beat and read-beat signals.
interface burst_main_memory_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
) ();
    logic              rd_mem;
    logic              wr_mem;
    logic [AWIDTH-1:0] addr_mem;
    logic [DWIDTH-1:0] wdata;
    logic              wvalid;
    logic [DWIDTH-1:0] rdata;
    logic              rvalid;
    logic              ready_mem;
    logic              err;

    // Requester side.
    modport master (
        output rd_mem, wr_mem, addr_mem, wdata, wvalid,
        input  rdata, rvalid, ready_mem, err
    );

    // Memory side.
    modport slave (
        input  rd_mem, wr_mem, addr_mem, wdata, wvalid,
        output rdata, rvalid, ready_mem, err
    );
endinterface

// File: rtl/burst_main_memory.sv
// Single-port burst memory: a request starts a fixed-length burst after a
// fixed access latency. Reads stream one beat per cycle; writes advance only
// on wvalid. The address wraps modulo the memory depth.
module burst_main_memory #(
    parameter int AWIDTH    = 9,
    parameter int DWIDTH    = 8,
    parameter int LATENCY   = 2,
    parameter int BURST_LEN = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    burst_main_memory_if.slave  bus
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [3:0] LAT_LAST  = 4'((LATENCY == 0) ? 0 : LATENCY - 1);
    localparam logic [4:0] BEAT_LAST = 5'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        lat_q;
    logic [4:0]        beat_q;
    logic [AWIDTH-1:0] addr_q;
    logic              wr_mode_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              rvalid_q;
    logic              err_q;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic rd_beat;
    logic wr_beat;
    logic beat;

    // A read beat happens every XFER cycle; a write beat only when data is offered.
    assign rd_beat = (state_q == XFER) && !wr_mode_q;
    assign wr_beat = (state_q == XFER) &&  wr_mode_q && bus.wvalid;
    assign beat    = rd_beat || wr_beat;

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.err       = err_q;
    assign bus.ready_mem = (state_q == IDLE);

    // Memory array write port; contents survive reset, a reset edge writes nothing.
    always_ff @(posedge clk) begin
        if (reset_n && wr_beat) begin
            mem_q[addr_q] <= bus.wdata;
        end
    end

    // Burst control FSM with registered read data, valid and error pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            wr_mode_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.rd_mem ^ bus.wr_mem) begin
                        addr_q    <= bus.addr_mem;
                        beat_q    <= '0;
                        lat_q     <= '0;
                        wr_mode_q <= bus.wr_mem;
                        state_q   <= (LATENCY == 0) ? XFER : WAIT;
                    end else if (bus.rd_mem && bus.wr_mem) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        state_q <= XFER;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (rd_beat) begin
                            rdata_q  <= mem_q[addr_q];
                            rvalid_q <= 1'b1;
                        end
                        addr_q <= addr_q + AWIDTH'(1);
                        beat_q <= beat_q + 5'd1;
                        if (beat_q == BEAT_LAST) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_main_memory.sv
// Randomized scoreboard bench for burst_main_memory at default parameters.
module tb_burst_main_memory;
    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int BL  = 4;

    typedef struct {
        logic [DW-1:0] d;
        bit            known;
    } exp_t;
    typedef logic [DW-1:0] beats_t [16];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference memory: plain array plus "has been written" flags.
    logic [DW-1:0] ref_mem [1 << AW];
    bit            known   [1 << AW];
    exp_t          sb_q [$];
    exp_t          mon_e;

    burst_main_memory_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    burst_main_memory #(.AWIDTH(AW), .DWIDTH(DW), .LATENCY(LAT), .BURST_LEN(BL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read beat the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (reset_n && bus.rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.known) chk("rdata", 32'(bus.rdata), 32'(mon_e.d));
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a);
        int first = -1;
        int hi = 0;
        int errs = 0;
        logic [AW-1:0] idx;
        bus.rd_mem = 1'b1;
        bus.addr_mem = a;
        step();
        bus.rd_mem = 1'b0;
        bus.addr_mem = AW'($urandom);
        chk("rd_accept_busy", 32'(bus.ready_mem), 32'd0);
        for (int b = 0; b < BL; b++) begin
            idx = a + AW'(b);
            sb_q.push_back('{d: ref_mem[idx], known: known[idx]});
        end
        for (int k = 1; k <= LAT + BL + 1; k++) begin
            bus.wvalid = 1'($urandom);
            bus.wdata  = DW'($urandom);
            bus.wr_mem = (k == 1);
            step();
            bus.wr_mem = 1'b0;
            if (bus.rvalid === 1'b1) begin
                hi++;
                if (first < 0) first = k;
            end
            if (bus.err !== 1'b0) errs++;
        end
        bus.wvalid = 1'b0;
        chk("rd_first_beat_edge", 32'(first), 32'(LAT + 1));
        chk("rd_beat_count", 32'(hi), 32'(BL));
        chk("rd_ready_after", 32'(bus.ready_mem), 32'd1);
        chk("rd_no_err", 32'(errs), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input beats_t d, input int stall_at,
                            input int stall_n, input int abort_after, input bit mid_req);
        int lows = 1;
        int errs = 0;
        int b = 0;
        int sl = stall_n;
        int guard = 0;
        logic [AW-1:0] idx;
        bus.wr_mem = 1'b1;
        bus.addr_mem = a;
        step();
        bus.wr_mem = 1'b0;
        bus.addr_mem = AW'($urandom);
        chk("wr_accept_busy", 32'(bus.ready_mem), 32'd0);
        // Data offered during the access latency must be ignored.
        for (int k = 1; k <= LAT; k++) begin
            bus.wvalid = 1'($urandom);
            bus.wdata  = DW'($urandom);
            bus.rd_mem = mid_req && (k == 1);
            step();
            bus.rd_mem = 1'b0;
            if (bus.ready_mem !== 1'b1) lows++;
            if (bus.err !== 1'b0) errs++;
        end
        while (b < BL && guard < 100) begin
            guard++;
            if (abort_after >= 0 && b == abort_after) begin
                bus.wvalid = 1'b1;
                bus.wdata  = d[b];
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
                bus.wvalid = 1'b0;
                chk("abort_ready", 32'(bus.ready_mem), 32'd1);
                chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
                chk("abort_rdata", 32'(bus.rdata), 32'd0);
                return;
            end
            if (b == stall_at && sl > 0) begin
                bus.wvalid = 1'b0;
                bus.wdata  = DW'($urandom);
                bus.rd_mem = mid_req;
                bus.wr_mem = mid_req;
                sl--;
            end else begin
                bus.wvalid = 1'b1;
                bus.wdata  = d[b];
                idx = a + AW'(b);
                ref_mem[idx] = d[b];
                known[idx] = 1'b1;
                b++;
            end
            step();
            bus.rd_mem = 1'b0;
            bus.wr_mem = 1'b0;
            if (bus.ready_mem !== 1'b1) lows++;
            if (bus.err !== 1'b0) errs++;
        end
        bus.wvalid = 1'b0;
        chk("wr_busy_cycles", 32'(lows), 32'(LAT + BL + stall_n - sl));
        chk("wr_ready_after", 32'(bus.ready_mem), 32'd1);
        chk("wr_no_err", 32'(errs), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beats_t d;
        bus.rd_mem = 1'b1;          // held during reset: must not be accepted
        bus.wr_mem = 1'b0;
        bus.addr_mem = '0;
        bus.wdata = '0;
        bus.wvalid = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
            known[i] = 1'b0;
        end
        reset_n = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus.ready_mem), 32'd1);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        bus.rd_mem = 1'b0;
        reset_n = 1'b1;
        step();

        // Basic write then read back.
        d = '{default: '0};
        d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3; d[3] = 8'hA4;
        do_write(9'h010, d, -1, 0, -1, 1'b0);
        do_read(9'h010);

        // Burst crossing the top of memory.
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        do_write(9'h1FE, d, -1, 0, -1, 1'b0);
        do_read(9'h1FE);
        do_read(9'h000);

        // Conflicting request: one-cycle error, nothing accepted.
        bus.rd_mem = 1'b1;
        bus.wr_mem = 1'b1;
        bus.addr_mem = 9'h010;
        step();
        bus.rd_mem = 1'b0;
        bus.wr_mem = 1'b0;
        chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_ready", 32'(bus.ready_mem), 32'd1);
        step();
        chk("err_clears", 32'(bus.err), 32'd0);
        chk("err_still_idle", 32'(bus.ready_mem), 32'd1);
        do_read(9'h010);

        // Stalled write with requests pulsed mid-burst.
        d[0] = 8'h5A; d[1] = 8'h6B; d[2] = 8'h7C; d[3] = 8'h8D;
        do_write(9'h080, d, 1, 3, -1, 1'b1);
        do_read(9'h080);

        // Reset after two write beats keeps only those two.
        d[0] = 8'hC0; d[1] = 8'hC1; d[2] = 8'hC2; d[3] = 8'hC3;
        do_write(9'h0C0, d, -1, 0, -1, 1'b0);
        d[0] = 8'hE0; d[1] = 8'hE1; d[2] = 8'hE2; d[3] = 8'hE3;
        do_write(9'h0C0, d, -1, 0, 2, 1'b0);
        step();
        do_read(9'h0C0);

        // Random mix concentrated around the wrap point.
        for (int it = 0; it < 40; it++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 31)) + 9'h1F0;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < BL; b++) d[b] = DW'($urandom);
                do_write(a, d, $urandom_range(0, BL), $urandom_range(0, 3), -1,
                         1'($urandom));
            end else begin
                do_read(a);
            end
            for (int g = 0; g < $urandom_range(0, 2); g++) step();
        end

        step();
        step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
